writeback_queue: RTL and testbench
==================================

Name: writeback_queue

Overview:
- Write-side front end for the CPU register file.
- Accepts destination-register write requests from two producers (ALU result port A, load/memory result port B), buffers them in order in a small FIFO, and drains one per cycle onto the register file's single write port (enable / rd_select / data_in).
- Provides a lookup on the read addresses so pending (not yet written) values are forwarded to the operand path.

Parameters:
- XLEN, 32, data width of every write value.
- DEPTH, 4, FIFO entries; power of two, >= 2.
- AW, 5, register address width (32 architectural registers).

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- reset  in  1  synchronous, active-low; state clears on a rising clk edge while reset==0.
- a_valid  in  1  port A write request.
- a_rd  in  AW  port A destination register.
- a_data  in  XLEN  port A write value.
- a_ready  out  1  port A accepted this cycle when a_valid && a_ready.
- b_valid  in  1  port B write request.
- b_rd  in  AW  port B destination register.
- b_data  in  XLEN  port B write value.
- b_ready  out  1  port B accepted this cycle when b_valid && b_ready.
- wb_stall  in  1  holds the drain; no register file write this cycle.
- wb_enable  out  1  drives register file enable.
- wb_rd  out  AW  drives register file rd_select.
- wb_data  out  XLEN  drives register file data_in.
- rs1, rs2  in  AW  operand read addresses, matching the register file read select inputs.
- fwd1_hit, fwd2_hit  out  1  a pending entry targets rs1 / rs2.
- fwd1_data, fwd2_data  out  XLEN  youngest pending value for rs1 / rs2.
- count  out  $clog2(DEPTH)+1  occupied entries.
- full, empty  out  1  count==DEPTH / count==0.

Behaviour:
- Storage is a circular FIFO with wr_ptr, rd_ptr and count. Each entry holds rd and data.
- Reset (reset==0 at an edge):
  - pointers and count go to 0, all entries invalidated;
  - after the edge: wb_enable=0, wb_rd=0, wb_data=0, fwd*_hit=0, fwd*_data=0, empty=1, full=0, count=0.
  - Reset wins over every simultaneous enqueue or drain; in-flight entries are discarded.
- Ready rules:
  - Depend only on registered count and a_valid, never on wb_stall.
  - free = DEPTH - count.
  - a_ready = (free >= 1).
  - b_ready = (free >= 2) || (free == 1 && !a_valid).
- Enqueue order: when both ports are accepted in one cycle, A is written at wr_ptr and B at wr_ptr+1 (A is older). wr_ptr wraps modulo DEPTH.
- Writes to rd==0:
  - accepted (ready honoured) but not stored; count does not change for that request;
  - such a request still consumes its slot in the ready calculation.
- Drain (combinational from the head):
  - wb_enable = !empty && !wb_stall;
  - wb_rd / wb_data = head entry when !empty, else 0.
  - On an edge with wb_enable=1, rd_ptr advances (wraps) and count decrements.
- Latency: a request accepted at edge N is visible at the head no earlier than cycle N+1 and is written at edge N+1 at the earliest, if the queue was empty and there is no stall.
- Simultaneous enqueue and drain: count_next = count + accepted_nonzero - drained.
  - When full, ready is 0 even if a drain occurs in the same cycle; there is no full-bypass.
- Forwarding (combinational):
  - fwdN_hit = 1 if rsN != 0 and any valid entry has rd == rsN.
  - fwdN_data = data of the youngest matching entry, else 0.
  - Same-cycle incoming requests are not forwarded; the producer bypass handles them.
  - The head entry being written this cycle still reports a hit.
- wb_stall only freezes the drain; enqueue continues until full.

Test Plan:
- Hold reset=0 for 2 edges with a_valid=1 -> count=0, empty=1, wb_enable=0, a_ready=1 after release.
- Queue empty; a_valid with rd=5, data=0x11 at edge N -> wb_enable=1, wb_rd=5, wb_data=0x11 in cycle N+1; empty=1 after edge N+1.
- A (rd=3, 0xA) and B (rd=3, 0xB) in the same cycle with wb_stall=1:
  - -> count=2, rs1=3 gives fwd1_hit=1, fwd1_data=0xB;
  - after stall drop, writes drain as 3/0xA then 3/0xB.
- Fill to DEPTH=4 with wb_stall=1 -> full=1, a_ready=0, b_ready=0; at count=3, a_valid=1 and b_valid=1 -> b_ready=0, only A accepted.
- a_rd=0 with data 0xFF -> a_ready=1, count unchanged, no wb_enable, rs1=0 gives fwd1_hit=0.
- 3 entries queued, reset=0 for one edge while draining -> next cycle count=0, wb_enable=0, fwd hits=0.

Source files
------------

// File: rtl/writeback_queue.sv
// Register-file write front end: two producers feed an in-order FIFO that drains
// one entry per cycle, with youngest-match forwarding of pending values to rs1/rs2.
module writeback_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int AW    = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     a_valid,
  input  logic [AW-1:0]            a_rd,
  input  logic [XLEN-1:0]          a_data,
  output logic                     a_ready,
  input  logic                     b_valid,
  input  logic [AW-1:0]            b_rd,
  input  logic [XLEN-1:0]          b_data,
  output logic                     b_ready,
  input  logic                     wb_stall,
  output logic                     wb_enable,
  output logic [AW-1:0]            wb_rd,
  output logic [XLEN-1:0]          wb_data,
  input  logic [AW-1:0]            rs1,
  input  logic [AW-1:0]            rs2,
  output logic                     fwd1_hit,
  output logic                     fwd2_hit,
  output logic [XLEN-1:0]          fwd1_data,
  output logic [XLEN-1:0]          fwd2_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0]   r_rd   [DEPTH];
  logic [XLEN-1:0] r_data [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  logic [CW-1:0]   w_free;
  logic            w_empty;
  logic            w_a_store;
  logic            w_b_store;
  logic            w_drain;
  logic [PW-1:0]   w_b_slot;
  logic [PW-1:0]   w_fwd_idx;

  // Ready looks only at registered occupancy; an rd==0 request still claims its slot here.
  assign w_free  = CW'(DEPTH) - r_count;
  assign a_ready = (w_free >= CW'(1));
  assign b_ready = (w_free >= CW'(2)) || ((w_free == CW'(1)) && !a_valid);

  assign w_a_store = a_valid && a_ready && (a_rd != {AW{1'b0}});
  assign w_b_store = b_valid && b_ready && (b_rd != {AW{1'b0}});
  assign w_b_slot  = r_wr_ptr + PW'(w_a_store);

  assign w_empty   = (r_count == {CW{1'b0}});
  assign w_drain   = !w_empty && !wb_stall;

  assign wb_enable = w_drain;
  assign wb_rd     = w_empty ? {AW{1'b0}}   : r_rd[r_rd_ptr];
  assign wb_data   = w_empty ? {XLEN{1'b0}} : r_data[r_rd_ptr];

  assign count = r_count;
  assign full  = (r_count == CW'(DEPTH));
  assign empty = w_empty;

  // FIFO storage, pointers and occupancy; reset discards everything in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
      r_count  <= {CW{1'b0}};
      r_valid  <= {DEPTH{1'b0}};
    end else begin
      if (w_drain) begin
        r_valid[r_rd_ptr] <= 1'b0;
      end
      if (w_a_store) begin
        r_rd[r_wr_ptr]    <= a_rd;
        r_data[r_wr_ptr]  <= a_data;
        r_valid[r_wr_ptr] <= 1'b1;
      end
      if (w_b_store) begin
        r_rd[w_b_slot]    <= b_rd;
        r_data[w_b_slot]  <= b_data;
        r_valid[w_b_slot] <= 1'b1;
      end
      r_wr_ptr <= r_wr_ptr + PW'(w_a_store) + PW'(w_b_store);
      r_rd_ptr <= r_rd_ptr + PW'(w_drain);
      r_count  <= r_count + CW'(w_a_store) + CW'(w_b_store) - CW'(w_drain);
    end
  end

  // Forwarding scan runs oldest to youngest so the last match is the youngest value.
  always_comb begin
    fwd1_hit  = 1'b0;
    fwd2_hit  = 1'b0;
    fwd1_data = {XLEN{1'b0}};
    fwd2_data = {XLEN{1'b0}};
    w_fwd_idx = {PW{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      w_fwd_idx = r_rd_ptr + PW'(i);
      if (r_valid[w_fwd_idx] && (rs1 != {AW{1'b0}}) && (r_rd[w_fwd_idx] == rs1)) begin
        fwd1_hit  = 1'b1;
        fwd1_data = r_data[w_fwd_idx];
      end else begin
        fwd1_hit  = fwd1_hit;
      end
      if (r_valid[w_fwd_idx] && (rs2 != {AW{1'b0}}) && (r_rd[w_fwd_idx] == rs2)) begin
        fwd2_hit  = 1'b1;
        fwd2_data = r_data[w_fwd_idx];
      end else begin
        fwd2_hit  = fwd2_hit;
      end
    end
  end

endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue: hand-computed expectations for reset, drain,
// ordering, forwarding, full/ready rules, rd==0 handling and mid-flight reset.
module tb_writeback_queue;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int AW    = 5;

  logic            clk;
  logic            reset;
  logic            a_valid;
  logic [AW-1:0]   a_rd;
  logic [XLEN-1:0] a_data;
  logic            a_ready;
  logic            b_valid;
  logic [AW-1:0]   b_rd;
  logic [XLEN-1:0] b_data;
  logic            b_ready;
  logic            wb_stall;
  logic            wb_enable;
  logic [AW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;
  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic            fwd1_hit;
  logic            fwd2_hit;
  logic [XLEN-1:0] fwd1_data;
  logic [XLEN-1:0] fwd2_data;
  logic [2:0]      count;
  logic            full;
  logic            empty;

  int n_checks;
  int n_pass;

  writeback_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
    .wb_stall(wb_stall), .wb_enable(wb_enable), .wb_rd(wb_rd), .wb_data(wb_data),
    .rs1(rs1), .rs2(rs2),
    .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit), .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
    .count(count), .full(full), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset = 1'b0; wb_stall = 1'b0; rs1 = 5'd0; rs2 = 5'd0;
    a_valid = 1'b1; a_rd = 5'd7; a_data = 32'h1;
    b_valid = 1'b0; b_rd = 5'd0; b_data = 32'h0;

    // reset held two edges with a_valid asserted
    step(); step();
    chk("rst_count", count, 64'd0);
    chk("rst_empty", empty, 64'd1);
    chk("rst_full", full, 64'd0);
    chk("rst_wben", wb_enable, 64'd0);
    chk("rst_wbrd", wb_rd, 64'd0);
    chk("rst_wbdata", wb_data, 64'd0);
    reset = 1'b1; a_valid = 1'b0;
    settle();
    chk("rst_aready", a_ready, 64'd1);
    chk("rst_count2", count, 64'd0);

    // single write, empty queue, no stall
    a_valid = 1'b1; a_rd = 5'd5; a_data = 32'h11;
    settle();
    chk("w1_aready", a_ready, 64'd1);
    step();
    a_valid = 1'b0;
    settle();
    chk("w1_wben", wb_enable, 64'd1);
    chk("w1_wbrd", wb_rd, 64'd5);
    chk("w1_wbdata", wb_data, 64'h11);
    chk("w1_count", count, 64'd1);
    step();
    chk("w1_empty", empty, 64'd1);
    chk("w1_wben_off", wb_enable, 64'd0);

    // A and B same rd same cycle under stall
    wb_stall = 1'b1;
    a_valid = 1'b1; a_rd = 5'd3; a_data = 32'hA;
    b_valid = 1'b1; b_rd = 5'd3; b_data = 32'hB;
    settle();
    chk("ab_bready", b_ready, 64'd1);
    step();
    a_valid = 1'b0; b_valid = 1'b0; rs1 = 5'd3;
    settle();
    chk("ab_count", count, 64'd2);
    chk("ab_hit", fwd1_hit, 64'd1);
    chk("ab_fdata", fwd1_data, 64'hB);
    chk("ab_stall_wben", wb_enable, 64'd0);
    wb_stall = 1'b0;
    settle();
    chk("ab_d1_en", wb_enable, 64'd1);
    chk("ab_d1_rd", wb_rd, 64'd3);
    chk("ab_d1_data", wb_data, 64'hA);
    chk("ab_d1_hit", fwd1_hit, 64'd1);
    step();
    chk("ab_d2_rd", wb_rd, 64'd3);
    chk("ab_d2_data", wb_data, 64'hB);
    chk("ab_d2_count", count, 64'd1);
    chk("ab_d2_fdata", fwd1_data, 64'hB);
    step();
    chk("ab_empty", empty, 64'd1);
    chk("ab_nohit", fwd1_hit, 64'd0);

    // fill to full under stall (pointers wrap here)
    wb_stall = 1'b1;
    a_valid = 1'b1; a_rd = 5'd1; a_data = 32'h101;
    b_valid = 1'b1; b_rd = 5'd2; b_data = 32'h102;
    step();
    chk("f_count2", count, 64'd2);
    b_valid = 1'b0; a_rd = 5'd4; a_data = 32'h104;
    step();
    chk("f_count3", count, 64'd3);
    a_rd = 5'd6; a_data = 32'h106;
    b_valid = 1'b1; b_rd = 5'd7; b_data = 32'h107;
    settle();
    chk("f3_aready", a_ready, 64'd1);
    chk("f3_bready", b_ready, 64'd0);
    step();
    rs1 = 5'd1; rs2 = 5'd6;
    settle();
    chk("f_count4", count, 64'd4);
    chk("f_full", full, 64'd1);
    chk("f_aready", a_ready, 64'd0);
    chk("f_bready", b_ready, 64'd0);
    chk("f_fwd1", fwd1_data, 64'h101);
    chk("f_fwd2", fwd2_data, 64'h106);
    rs2 = 5'd7;
    settle();
    chk("f_b_dropped", fwd2_hit, 64'd0);
    // no bypass when full even while draining
    wb_stall = 1'b0;
    settle();
    chk("fb_wben", wb_enable, 64'd1);
    chk("fb_aready", a_ready, 64'd0);
    step();
    a_valid = 1'b0; b_valid = 1'b0; rs1 = 5'd4;
    settle();
    chk("fb_count", count, 64'd3);
    chk("fb_head_rd", wb_rd, 64'd2);
    chk("fb_head_data", wb_data, 64'h102);
    chk("fb_fwd1", fwd1_data, 64'h104);

    // reset while draining three entries
    reset = 1'b0;
    step();
    reset = 1'b1;
    rs2 = 5'd6;
    settle();
    chk("mr_count", count, 64'd0);
    chk("mr_wben", wb_enable, 64'd0);
    chk("mr_hit1", fwd1_hit, 64'd0);
    chk("mr_hit2", fwd2_hit, 64'd0);
    chk("mr_fdata1", fwd1_data, 64'd0);
    chk("mr_empty", empty, 64'd1);

    // rd==0 is accepted but dropped
    rs1 = 5'd0; rs2 = 5'd0;
    a_valid = 1'b1; a_rd = 5'd0; a_data = 32'hFF;
    settle();
    chk("z_aready", a_ready, 64'd1);
    step();
    a_valid = 1'b0;
    settle();
    chk("z_count", count, 64'd0);
    chk("z_wben", wb_enable, 64'd0);
    chk("z_hit", fwd1_hit, 64'd0);

    // rd==0 on A with valid B: B lands at the head
    a_valid = 1'b1; a_rd = 5'd0; a_data = 32'hFF;
    b_valid = 1'b1; b_rd = 5'd9; b_data = 32'h99;
    step();
    a_valid = 1'b0; b_valid = 1'b0; rs1 = 5'd9;
    settle();
    chk("zb_count", count, 64'd1);
    chk("zb_rd", wb_rd, 64'd9);
    chk("zb_data", wb_data, 64'h99);
    chk("zb_fwd", fwd1_data, 64'h99);
    step();
    chk("zb_empty", empty, 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
